// File: rtl/ads131_spi_pkg.sv
// Shared definitions for the ADS131A0X SPI interface blocks.
package ads131_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rx_state_t;

  localparam int unsigned DEFAULT_WORD_BITS       = 16;
  localparam int unsigned DEFAULT_WORDS_PER_FRAME = 4;

  // SCLK level between transfers; the generator drives this level when idle.
  localparam logic SCLK_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/spi_input_synchronizer.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses.
module spi_input_synchronizer #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_LEVEL}};
      prev  <= RESET_LEVEL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/ads131_spi_frame_receiver.sv
// Oversampling SPI receiver: shifts in ADS131A0X response frames MSB-first
// and strobes each completed word, flagging frames cut short by CS.
module ads131_spi_frame_receiver
  import ads131_spi_pkg::*;
#(
  parameter int unsigned WORD_BITS       = DEFAULT_WORD_BITS,
  parameter int unsigned WORDS_PER_FRAME = DEFAULT_WORDS_PER_FRAME,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 SPI_SCLK,
  input  logic                 SPI_CS_N,
  input  logic                 SPI_MISO,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 word_valid,
  output logic [2:0]           word_index,
  output logic                 frame_done,
  output logic                 frame_error,
  output logic [7:0]           bit_count
);

  localparam logic [5:0] LAST_BIT  = 6'(WORD_BITS - 1);
  localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_FRAME - 1);

  rx_state_t state, state_next;

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic sclk_unused;
  logic [SYNC_STAGES-1:0] miso_chain;
  logic miso_sync;

  logic [SYNC_STAGES:0]   settle;
  logic                   armed;
  logic [WORD_BITS-1:0]   shift_reg;
  logic [5:0]             bit_in_word;
  logic                   pending;
  logic                   start, shift_en, abort;

  spi_input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_LEVEL(SCLK_IDLE_LEVEL)) u_sclk_sync (
    .clk(system_clock), .rst(reset), .din(SPI_SCLK),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_cs_sync (
    .clk(system_clock), .rst(reset), .din(SPI_CS_N),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  assign sclk_unused = sclk_level ^ sclk_rise;

  // Same depth as the SCLK/CS chains so MISO lines up with the sampled edge.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) miso_chain <= '0;
    else       miso_chain <= {miso_chain[SYNC_STAGES-2:0], SPI_MISO};
  end
  assign miso_sync = miso_chain[SYNC_STAGES-1];

  // A CS already low at reset release shows up as a fall once the chain
  // flushes; only accept frames after CS has been seen high post-flush.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      armed  <= armed | (settle[SYNC_STAGES] & cs_level);
    end
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall && armed) begin
          start      = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (sclk_fall) begin
          shift_en = 1'b1;
          if (bit_in_word == LAST_BIT && word_index == LAST_WORD) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cs_rise) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      shift_reg   <= '0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      word_index  <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      bit_count   <= '0;
      bit_in_word <= '0;
      pending     <= 1'b0;
    end else begin
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= abort;
      if (pending) begin
        pending    <= 1'b0;
        word_valid <= 1'b1;
        word_data  <= shift_reg;
        frame_done <= (word_index == LAST_WORD);
      end
      if (word_valid && word_index != LAST_WORD) word_index <= word_index + 3'd1;
      if (start) begin
        bit_count   <= '0;
        bit_in_word <= '0;
        word_index  <= '0;
      end else if (shift_en) begin
        shift_reg <= {shift_reg[WORD_BITS-2:0], miso_sync};
        if (bit_count != 8'hFF) bit_count <= bit_count + 8'd1;
        if (bit_in_word == LAST_BIT) begin
          bit_in_word <= '0;
          pending     <= 1'b1;
        end else begin
          bit_in_word <= bit_in_word + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ads131_spi_frame_receiver.sv
// Scoreboard bench for ads131_spi_frame_receiver (16-bit and 24-bit instances).
module tb_ads131_spi_frame_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic miso = 1'b0;
  logic cs16 = 1'b1;
  logic cs24 = 1'b1;

  logic [15:0] wd16;
  logic        v16, fd16, fe16;
  logic [2:0]  wi16;
  logic [7:0]  bc16;
  logic [23:0] wd24;
  logic        v24, fd24, fe24;
  logic [2:0]  wi24;
  logic [7:0]  bc24;

  always #10 clk = ~clk;

  ads131_spi_frame_receiver #(.WORD_BITS(16), .WORDS_PER_FRAME(4), .SYNC_STAGES(2)) dut16 (
    .system_clock(clk), .reset(rst), .SPI_SCLK(sclk), .SPI_CS_N(cs16), .SPI_MISO(miso),
    .word_data(wd16), .word_valid(v16), .word_index(wi16), .frame_done(fd16),
    .frame_error(fe16), .bit_count(bc16)
  );

  ads131_spi_frame_receiver #(.WORD_BITS(24), .WORDS_PER_FRAME(4), .SYNC_STAGES(2)) dut24 (
    .system_clock(clk), .reset(rst), .SPI_SCLK(sclk), .SPI_CS_N(cs24), .SPI_MISO(miso),
    .word_data(wd24), .word_valid(v24), .word_index(wi24), .frame_done(fd24),
    .frame_error(fe24), .bit_count(bc24)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        done;
  } exp_t;

  exp_t        q16[$];
  exp_t        q24[$];
  int          checks = 0;
  int          passed = 0;
  int          err16 = 0;
  int          err24 = 0;
  logic [31:0] words[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (v16) begin
      check("w16_expected", 32'(q16.size() != 0), 1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        check("w16_data", {16'h0, wd16}, e.data);
        check("w16_index", {29'h0, wi16}, {29'h0, e.idx});
        check("w16_done", {31'h0, fd16}, {31'h0, e.done});
      end
    end
    if (fd16) check("fd16_with_valid", {31'h0, v16}, 1);
    if (fe16) err16++;
    if (v24) begin
      check("w24_expected", 32'(q24.size() != 0), 1);
      if (q24.size() != 0) begin
        e = q24.pop_front();
        check("w24_data", {8'h0, wd24}, e.data);
        check("w24_index", {29'h0, wi24}, {29'h0, e.idx});
        check("w24_done", {31'h0, fd24}, {31'h0, e.done});
      end
    end
    if (fd24) check("fd24_with_valid", {31'h0, v24}, 1);
    if (fe24) err24++;
  end

  task automatic sbit(input logic b);
    miso = b;
    sclk = 1'b1;
    #120;
    sclk = 1'b0;
    #120;
  endtask

  task automatic cs_set(input int sel, input logic v);
    if (sel == 0) cs16 = v;
    else cs24 = v;
    #240;
  endtask

  // Queues an expectation for every whole word covered by nbits, then clocks
  // the bits out MSB-first; bits beyond the frame are sent as ones.
  task automatic send(input int sel, input int wb, input int nbits);
    exp_t e;
    logic b;
    for (int k = 0; k < 4; k++) begin
      if (nbits >= (k + 1) * wb) begin
        e.data = words[k];
        e.idx  = 3'(k);
        e.done = (k == 3);
        if (sel == 0) q16.push_back(e);
        else q24.push_back(e);
      end
    end
    for (int i = 0; i < nbits; i++) begin
      if (i < 4 * wb) b = words[i / wb][wb - 1 - (i % wb)];
      else b = 1'b1;
      sbit(b);
    end
  endtask

  initial begin
    #50;
    check("rst_word_data", {16'h0, wd16}, 0);
    check("rst_valid", {31'h0, v16}, 0);
    check("rst_index", {29'h0, wi16}, 0);
    check("rst_done_err", {30'h0, fd16, fe16}, 0);
    check("rst_bit_count", {24'h0, bc16}, 0);
    #50;
    rst = 1'b0;
    #200;

    // Full frame
    words[0] = 32'hA5A5; words[1] = 32'h1234; words[2] = 32'hFFFF; words[3] = 32'h0001;
    cs_set(0, 1'b0);
    send(0, 16, 64);
    #240;
    check("t1_bit_count", {24'h0, bc16}, 64);
    cs_set(0, 1'b1);
    #200;
    check("t1_all_words", q16.size(), 0);
    check("t1_errors", err16, 0);

    // Frame cut after 20 bits, then a clean frame
    words[0] = 32'h5A5A; words[1] = 32'hFFFF; words[2] = 32'h0000; words[3] = 32'hFFFF;
    cs_set(0, 1'b0);
    send(0, 16, 20);
    cs_set(0, 1'b1);
    #200;
    check("t2_words", q16.size(), 0);
    check("t2_errors", err16, 1);
    words[0] = 32'hDEAD; words[1] = 32'hBEEF; words[2] = 32'h0F0F; words[3] = 32'h8000;
    cs_set(0, 1'b0);
    send(0, 16, 64);
    cs_set(0, 1'b1);
    #200;
    check("t2_next_frame", q16.size(), 0);
    check("t2_errors_after", err16, 1);

    // Extra SCLK edges beyond the frame
    words[0] = 32'h1111; words[1] = 32'h2222; words[2] = 32'h4444; words[3] = 32'h8888;
    cs_set(0, 1'b0);
    send(0, 16, 70);
    #240;
    check("t3_bit_count_hold", {24'h0, bc16}, 64);
    cs_set(0, 1'b1);
    #200;
    check("t3_words", q16.size(), 0);
    check("t3_errors", err16, 1);

    // CS rise coincident with the final SCLK fall
    words[0] = 32'h0102; words[1] = 32'h0304; words[2] = 32'h0506; words[3] = 32'h0708;
    cs_set(0, 1'b0);
    send(0, 16, 63);
    miso = words[3][0];
    sclk = 1'b1;
    #120;
    sclk = 1'b0;
    cs16 = 1'b1;
    #440;
    check("t4_words", q16.size(), 0);
    check("t4_errors", err16, 2);

    // Reset mid-frame while CS stays low
    words[0] = 32'hCAFE; words[1] = 32'h0000; words[2] = 32'h0000; words[3] = 32'h0000;
    cs_set(0, 1'b0);
    send(0, 16, 30);
    check("t5_bit_count_pre", {24'h0, bc16}, 30);
    rst = 1'b1;
    #1;
    check("t5_rst_bit_count", {24'h0, bc16}, 0);
    check("t5_rst_index", {29'h0, wi16}, 0);
    check("t5_rst_word_data", {16'h0, wd16}, 0);
    #39;
    rst = 1'b0;
    #100;
    for (int i = 0; i < 34; i++) sbit(1'b1);
    #200;
    check("t5_no_count", {24'h0, bc16}, 0);
    check("t5_no_words", q16.size(), 0);
    cs_set(0, 1'b1);
    words[0] = 32'h0F1E; words[1] = 32'h2D3C; words[2] = 32'h4B5A; words[3] = 32'h6978;
    cs_set(0, 1'b0);
    send(0, 16, 64);
    cs_set(0, 1'b1);
    #200;
    check("t5_frame_after", q16.size(), 0);
    check("t5_errors", err16, 2);

    // 24-bit words
    words[0] = 32'hC00000; words[1] = 32'h7FFFFF; words[2] = 32'h800000; words[3] = 32'h000001;
    cs_set(1, 1'b0);
    send(1, 24, 96);
    #240;
    check("t6_bit_count", {24'h0, bc24}, 96);
    cs_set(1, 1'b1);
    #200;
    check("t6_words", q24.size(), 0);
    check("t6_errors", err24, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
